v_down_timer: RTL and testbench



---
 rtl/v_down_timer.sv | 67 ++++++
 tb/tb_v_down_timer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/v_down_timer.sv
// Loadable down-counting interval timer with one-shot and auto-reload modes.
// Counts a reloaded value down to zero and pulses TC for one cycle at terminal count.
module v_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             SLOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             CE,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             BUSY
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, stateNext;
  logic [WIDTH-1:0] rld, rldNext, qNext;
  logic             tcNext;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= IDLE;
      rld   <= '0;
      Q     <= '0;
      TC    <= 1'b0;
    end else begin
      state <= stateNext;
      rld   <= rldNext;
      Q     <= qNext;
      TC    <= tcNext;
    end
  end

  // Priority is load, then start/retrigger, then a count step; at zero the
  // counter either reloads (periodic) or parks at zero and drops to idle.
  always_comb begin
    stateNext = state;
    rldNext   = rld;
    qNext     = Q;
    tcNext    = 1'b0;
    if (SLOAD) begin
      rldNext   = D;
      qNext     = D;
      stateNext = IDLE;
    end else if (START) begin
      qNext     = rld;
      stateNext = RUN;
    end else if (state == RUN && CE) begin
      if (Q != '0) begin
        qNext = Q - ONE;
      end else begin
        tcNext = 1'b1;
        if (MODE) qNext = rld;
        else      stateNext = IDLE;
      end
    end
  end

  assign BUSY = (state == RUN);

endmodule

// File: tb/tb_v_down_timer.sv
// Directed bench for v_down_timer: a vector table for single-edge behaviour
// plus hand-written sequences for async reset, CE gating and an 8-bit period.
module tb_v_down_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sLoad = 1'b0;
  logic       start = 1'b0;
  logic       ce    = 1'b0;
  logic       mode  = 1'b0;
  logic [3:0] d4    = '0;
  logic [7:0] d8    = '0;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       tc4, busy4, tc8, busy8;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic       sl;
    logic       st;
    logic       en;
    logic       md;
    logic [3:0] d;
    logic [3:0] q;
    logic       tc;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  v_down_timer #(.WIDTH(4)) dut4 (
    .C(clock), .CLR(reset), .SLOAD(sLoad), .D(d4), .START(start),
    .CE(ce), .MODE(mode), .Q(q4), .TC(tc4), .BUSY(busy4)
  );

  v_down_timer #(.WIDTH(8)) dut8 (
    .C(clock), .CLR(reset), .SLOAD(sLoad), .D(d8), .START(start),
    .CE(ce), .MODE(mode), .Q(q8), .TC(tc8), .BUSY(busy8)
  );

  // Drive inputs just after an edge, then wait for the next edge and settle.
  task automatic applyStimulus(input logic sl, input logic st, input logic en,
                               input logic md, input logic [3:0] dv);
    sLoad = sl;
    start = st;
    ce    = en;
    mode  = md;
    d4    = dv;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expQ,
                             input logic expTc, input logic expBusy);
    checks++;
    if ({q4, tc4, busy4} === {expQ, expTc, expBusy}) passed++;
    else $display("[TB] FAIL %s: got Q=%0d TC=%b BUSY=%b, want Q=%0d TC=%b BUSY=%b",
                  name, q4, tc4, busy4, expQ, expTc, expBusy);
  endtask

  task automatic checkValue(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, act, expv);
  endtask

  initial begin
    //            sl st en md  d     q  tc busy
    vecs.push_back('{1, 0, 0, 0, 4'd3, 4'd3, 0, 0}); // one-shot load
    vecs.push_back('{0, 1, 0, 0, 4'd0, 4'd3, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 4'd0, 4'd2, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 4'd0, 4'd1, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 4'd0, 4'd0, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 4'd0, 4'd0, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 4'd0, 4'd0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 4'd0, 4'd0, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 4'd2, 4'd2, 0, 0}); // periodic load
    vecs.push_back('{0, 1, 0, 1, 4'd0, 4'd2, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd1, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd0, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd2, 1, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd1, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd0, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd2, 1, 1});
    vecs.push_back('{0, 0, 0, 1, 4'd0, 4'd2, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd1, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 4'd0, 4'd1, 0, 1});
    vecs.push_back('{0, 1, 1, 1, 4'd0, 4'd2, 0, 1}); // retrigger at Q=1
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd1, 0, 1});
    vecs.push_back('{1, 0, 1, 1, 4'd7, 4'd7, 0, 0}); // load mid-run
    vecs.push_back('{1, 1, 1, 1, 4'd5, 4'd5, 0, 0}); // load beats start
    vecs.push_back('{0, 1, 0, 1, 4'd0, 4'd5, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd4, 0, 1});
    vecs.push_back('{1, 0, 0, 1, 4'd0, 4'd0, 0, 0}); // reload value zero
    vecs.push_back('{0, 1, 0, 1, 4'd0, 4'd0, 0, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd0, 1, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd0, 1, 1});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd0, 1, 1});
    vecs.push_back('{0, 0, 1, 0, 4'd0, 4'd0, 1, 0}); // one-shot at zero
    vecs.push_back('{0, 0, 1, 0, 4'd0, 4'd0, 0, 0});
    vecs.push_back('{0, 0, 1, 1, 4'd0, 4'd0, 0, 0}); // idle ignores CE

    #2 reset = 1'b1;
    #2 checkOutput("reset state", 4'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sl, vecs[i].st, vecs[i].en, vecs[i].md, vecs[i].d);
      checkOutput($sformatf("vec %0d", i), vecs[i].q, vecs[i].tc, vecs[i].busy);
    end

    // Asynchronous clear in the middle of a run, with no clock edge.
    applyStimulus(1, 0, 0, 1, 4'd5);
    applyStimulus(0, 1, 0, 1, 4'd0);
    checkOutput("running at 5", 4'd5, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 checkOutput("async clear", 4'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1 checkOutput("clear held", 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(0, 0, 1, 1, 4'd0);
    checkOutput("idle after clear", 4'd0, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 1, 4'd0);
    checkOutput("start after clear", 4'd0, 1'b0, 1'b1);

    // CE toggling every clock: Q moves only on enabled edges, TC every 10 clocks.
    begin
      logic [3:0] modelQ;
      logic       modelTc;
      int         firstTc, secondTc;
      firstTc  = -1;
      secondTc = -1;
      applyStimulus(1, 0, 0, 1, 4'd4);
      applyStimulus(0, 1, 0, 1, 4'd0);
      checkOutput("gated start", 4'd4, 1'b0, 1'b1);
      modelQ = 4'd4;
      for (int i = 0; i < 30; i++) begin
        logic en;
        en = (i % 2 == 0);
        modelTc = 1'b0;
        if (en) begin
          if (modelQ == 4'd0) begin
            modelQ  = 4'd4;
            modelTc = 1'b1;
          end else begin
            modelQ = modelQ - 4'd1;
          end
        end
        applyStimulus(0, 0, en, 1, 4'd0);
        checkOutput($sformatf("gated cycle %0d", i), modelQ, modelTc, 1'b1);
        if (tc4) begin
          if (firstTc < 0) firstTc = i;
          else if (secondTc < 0) secondTc = i;
        end
      end
      checkValue("gated first tc", firstTc, 8);
      checkValue("gated tc period", secondTc - firstTc, 10);
    end

    // 8-bit instance at full scale: 256 count steps per TC, no wrap.
    begin
      logic [7:0] modelQ8;
      int         badCycles, firstTc, secondTc;
      badCycles = 0;
      firstTc   = -1;
      secondTc  = -1;
      d8 = 8'hFF;
      applyStimulus(1, 0, 0, 1, 4'd0);
      checkValue("w8 load", int'(q8), 255);
      applyStimulus(0, 1, 0, 1, 4'd0);
      checkValue("w8 busy", int'(busy8), 1);
      modelQ8 = 8'hFF;
      for (int i = 1; i <= 600 && secondTc < 0; i++) begin
        logic expTc;
        expTc = (modelQ8 == 8'd0);
        modelQ8 = expTc ? 8'hFF : modelQ8 - 8'd1;
        applyStimulus(0, 0, 1, 1, 4'd0);
        if (q8 !== modelQ8 || tc8 !== expTc) badCycles++;
        if (tc8) begin
          if (firstTc < 0) firstTc = i;
          else secondTc = i;
        end
      end
      checkValue("w8 bad cycles", badCycles, 0);
      checkValue("w8 first tc step", firstTc, 256);
      checkValue("w8 tc period", secondTc - firstTc, 256);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
